// File: rtl/inst_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inst_loader_pkg
//  Brief    : Shared constants and FSM state encoding for the instruction
//             memory boot loader.
//  Options  : INST_LOADER_CHECKSUM_EN (checksum trailer after the image)
//  Revision : 1.0  initial release
// ============================================================================
package inst_loader_pkg;

  localparam int CPU_WIDTH           = 32;
  localparam int INST_MEM_ADDR_WIDTH = 5;
  localparam int INST_MEM_ADDR_DEPTH = 1 << INST_MEM_ADDR_WIDTH;

  // S_CSUM is only reachable when the checksum option is compiled in.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4,
    S_CSUM  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/inst_loader_word_packer.sv
`default_nettype none
// ============================================================================
//  Module   : word_packer
//  Brief    : Shifts bytes into a little-endian word. The word output already
//             includes the byte being pushed, so when full pulses the complete
//             word is visible in the same cycle as its last byte.
//  Revision : 1.0  initial release
// ============================================================================
module word_packer
  import inst_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 push,
  input  logic [7:0]           byte_in,   // "byte" is a reserved word in SV
  output logic [CPU_WIDTH-1:0] word,
  output logic                 full
);

  logic [CPU_WIDTH-1:0] shreg;
  logic [1:0]           cnt;

  // Each new byte enters at the top so the first byte ends up in [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= 2'd0;
    end else if (clr) begin
      shreg <= '0;
      cnt   <= 2'd0;
    end else if (push) begin
      shreg <= {byte_in, shreg[CPU_WIDTH-1:8]};
      cnt   <= cnt + 2'd1;
    end
  end

  assign word = push ? {byte_in, shreg[CPU_WIDTH-1:8]} : shreg;
  assign full = push && (cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
//  Module   : inst_loader
//  Brief    : Boot-time instruction memory writer. Receives a length-prefixed
//             little-endian byte stream and writes consecutive words from
//             address 0 while holding the core in reset.
//  Options  : INST_LOADER_CHECKSUM_EN adds a 4-byte checksum trailer that must
//             equal the 32-bit sum of all written words.
//  Revision : 1.0  initial release
// ============================================================================
module inst_loader
  import inst_loader_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           byte_vld,
  input  logic [7:0]                     byte_data,
  output logic                           byte_rdy,
  output logic                           wr_en,
  output logic [INST_MEM_ADDR_WIDTH-1:0] wr_addr,
  output logic [CPU_WIDTH-1:0]           wr_data,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic                           cpu_hold
);

  // One extra index bit so a full-depth image terminates without wrapping.
  localparam int                   IW      = INST_MEM_ADDR_WIDTH + 1;
  localparam logic [CPU_WIDTH-1:0] DEPTH_W = CPU_WIDTH'(INST_MEM_ADDR_DEPTH);

  state_t               state;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        n_words;
  logic [IW-1:0]        idx_nxt;
  logic                 push;
  logic                 full;
  logic [CPU_WIDTH-1:0] word;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [CPU_WIDTH-1:0] csum;
`endif

  // byte_rdy is a register, so the only input-to-output dependency is registered.
  assign push    = byte_vld & byte_rdy;
  assign idx_nxt = idx + IW'(1);

  word_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == S_IDLE),
    .push    (push),
    .byte_in (byte_data),
    .word    (word),
    .full    (full)
  );

  // Load sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      n_words  <= '0;
      byte_rdy <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LEN;
            idx      <= '0;
            wr_addr  <= '0;
            err      <= 1'b0;
            byte_rdy <= 1'b1;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        S_LEN: begin
          if (full) begin
            if (word == '0) begin
`ifdef INST_LOADER_CHECKSUM_EN
              state    <= S_CSUM;
`else
              state    <= S_FIN;
              byte_rdy <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else if (word > DEPTH_W) begin
              state    <= S_IDLE;
              err      <= 1'b1;
              byte_rdy <= 1'b0;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
            end else begin
              state   <= S_DATA;
              n_words <= word[IW-1:0];
            end
          end
        end
        S_DATA: begin
          if (full) begin
            state    <= S_WRITE;
            byte_rdy <= 1'b0;
            wr_en    <= 1'b1;
            wr_addr  <= idx[INST_MEM_ADDR_WIDTH-1:0];
            wr_data  <= word;
          end
        end
        S_WRITE: begin
          idx <= idx_nxt;
`ifdef INST_LOADER_CHECKSUM_EN
          csum <= csum + wr_data;
`endif
          if (idx_nxt == n_words) begin
`ifdef INST_LOADER_CHECKSUM_EN
            state    <= S_CSUM;
            byte_rdy <= 1'b1;
`else
            state    <= S_FIN;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
`endif
          end else begin
            state    <= S_DATA;
            byte_rdy <= 1'b1;
          end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (full) begin
            byte_rdy <= 1'b0;
            cpu_hold <= 1'b0;
            if (word == csum) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state <= S_IDLE;
              err   <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
`endif
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          byte_rdy <= 1'b0;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_loader
//  Brief    : Randomized self-checking bench for inst_loader. Expected writes
//             and terminal events (done/err) are queued when a load is issued
//             and popped by an independent monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_loader;
  import inst_loader_pkg::*;

  localparam int AW = INST_MEM_ADDR_WIDTH;
`ifdef INST_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 byte_vld = 1'b0;
  logic [7:0]           byte_data = 8'h00;
  logic                 byte_rdy;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [CPU_WIDTH-1:0] wr_data;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 cpu_hold;

  inst_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .byte_vld  (byte_vld),
    .byte_data (byte_data),
    .byte_rdy  (byte_rdy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_hold  (cpu_hold)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [AW-1:0]        addr;
    logic [CPU_WIDTH-1:0] data;
  } wr_t;

  wr_t  exp_wr[$];
  int   exp_evt[$];
  int   checks = 0;
  int   failures = 0;
  int   last_done_cyc = 0;
  logic err_q = 1'b0;
  wr_t  mon_w;
  int   mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write and every terminal event must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_wr_en", 64'(wr_en), 64'd0);
        end else begin
          mon_w = exp_wr.pop_front();
          chk("wr_addr", 64'(wr_addr), 64'(mon_w.addr));
          chk("wr_data", 64'(wr_data), 64'(mon_w.data));
          chk("byte_rdy_during_write", 64'(byte_rdy), 64'd0);
        end
      end
      if (done) begin
        last_done_cyc <= cyc;
        mon_e = (exp_evt.size() == 0) ? 0 : exp_evt.pop_front();
        chk("done_event", 64'(EV_DONE), 64'(mon_e));
        chk("cpu_hold_at_done", 64'(cpu_hold), 64'd0);
      end
      if (err && !err_q) begin
        mon_e = (exp_evt.size() == 0) ? 0 : exp_evt.pop_front();
        chk("err_event", 64'(EV_ERR), 64'(mon_e));
      end
      err_q <= err;
    end else begin
      err_q <= 1'b0;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_byte_rdy"}, 64'(byte_rdy), 64'd0);
    chk({tag, "_wr_en"},    64'(wr_en),    64'd0);
    chk({tag, "_wr_addr"},  64'(wr_addr),  64'd0);
    chk({tag, "_wr_data"},  64'(wr_data),  64'd0);
    chk({tag, "_busy"},     64'(busy),     64'd0);
    chk({tag, "_done"},     64'(done),     64'd0);
    chk({tag, "_err"},      64'(err),      64'd0);
    chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
  endtask

  // Issue one load. abort_after >= 0 pulls reset after that many accepted bytes.
  task automatic run_load(input logic [31:0] n, input logic [31:0] words[$],
                          input int vld_pct, input bit noise, input bit bad,
                          input int abort_after);
    logic [7:0]  s[$];
    logic [31:0] sum;
    logic [31:0] cs;
    int          i;
    int          budget;
    int          t0;
    bit          acc;
    bit          ok_len;
    ok_len = (n <= 32'(INST_MEM_ADDR_DEPTH));
    sum = 32'd0;
    for (int b = 0; b < 4; b++) s.push_back(n[8*b +: 8]);
    if (ok_len) begin
      for (int k = 0; k < int'(n); k++) begin
        for (int b = 0; b < 4; b++) s.push_back(words[k][8*b +: 8]);
        sum = sum + words[k];
      end
      if (CSUM_ON) begin
        cs = bad ? (sum + 32'd1) : sum;
        for (int b = 0; b < 4; b++) s.push_back(cs[8*b +: 8]);
      end
    end
    if (abort_after < 0) begin
      if (ok_len) begin
        for (int k = 0; k < int'(n); k++) exp_wr.push_back({AW'(k), words[k]});
        exp_evt.push_back(bad ? EV_ERR : EV_DONE);
      end else begin
        exp_evt.push_back(EV_ERR);
      end
    end

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("err_cleared_by_start", 64'(err), 64'd0);

    i = 0;
    budget = 0;
    while (i < s.size() && budget < 5000) begin
      byte_vld  = ($urandom_range(99) < vld_pct);
      byte_data = byte_vld ? s[i] : 8'($urandom);
      start     = noise && ($urandom_range(7) == 0);
      acc       = byte_vld && byte_rdy;
      @(negedge clk);
      budget++;
      if (acc) i++;
      if (abort_after >= 0 && i == abort_after) begin
        byte_vld = 1'b0;
        start    = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    byte_vld = 1'b0;
    start    = 1'b0;
    if (budget >= 5000) chk("byte_feed_timeout", 64'(i), 64'(s.size()));

    budget = 0;
    while ((exp_wr.size() != 0 || exp_evt.size() != 0) && budget < 200) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (budget >= 200) chk("completion_timeout", 64'(exp_wr.size() + exp_evt.size()), 64'd0);

    if (vld_pct == 100 && ok_len && !bad)
      chk("done_latency", 64'(last_done_cyc - t0),
          64'(4 + 5 * int'(n) + (CSUM_ON ? 4 : 0)));

    repeat (2) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_cpu_hold", 64'(cpu_hold), 64'd0);
    chk("idle_err", 64'(err), 64'(bad || !ok_len));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[$];
    int          n;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed image from the boot example, full throughput.
    w = '{32'h00100513, 32'h00200593};
    run_load(32'd2, w, 100, 1'b0, 1'b0, -1);

    // Empty image: done without any write.
    w = '{};
    run_load(32'd0, w, 100, 1'b0, 1'b0, -1);

    // Oversized count: error, no writes, back to idle; error is sticky.
    run_load(32'(INST_MEM_ADDR_DEPTH + 1), w, 100, 1'b0, 1'b0, -1);
    repeat (3) @(negedge clk);
    chk("err_sticky", 64'(err), 64'd1);
    chk("rdy_low_after_err", 64'(byte_rdy), 64'd0);

    // Throttled valid with spurious start pulses.
    w = '{};
    for (int k = 0; k < 3; k++) w.push_back($urandom);
    run_load(32'd3, w, 50, 1'b1, 1'b0, -1);

    // Reset after six bytes of a four-word image, then a clean reload.
    w = '{};
    for (int k = 0; k < 4; k++) w.push_back($urandom);
    run_load(32'd4, w, 100, 1'b0, 1'b0, 6);
    chk("abort_queue_empty", 64'(exp_wr.size()), 64'd0);
    run_load(32'd4, w, 100, 1'b0, 1'b0, -1);

    // Full-depth image terminates exactly at the last address.
    w = '{};
    for (int k = 0; k < INST_MEM_ADDR_DEPTH; k++) w.push_back($urandom);
    run_load(32'(INST_MEM_ADDR_DEPTH), w, 100, 1'b0, 1'b0, -1);

    // Randomized loads.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 9);
      w = '{};
      for (int k = 0; k < n; k++) w.push_back($urandom);
      run_load(32'(n), w, $urandom_range(30, 100), 1'b1, 1'b0, -1);
    end

`ifdef INST_LOADER_CHECKSUM_EN
    w = '{32'h00000013};
    run_load(32'd1, w, 100, 1'b0, 1'b0, -1);
    run_load(32'd1, w, 100, 1'b0, 1'b1, -1);
`endif

    chk("leftover_writes", 64'(exp_wr.size()), 64'd0);
    chk("leftover_events", 64'(exp_evt.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
